// File: rtl/adder_pkg.sv
// Package: adder_pkg
// Purpose: shared definitions for the add/subtract datapath (pipelined_adder, ALU).
//   - op_e          : operation encoding carried on the 'sub' control bit
//   - CHUNK_DEFAULT : default slice width for one pipeline stage
//   - bp_offset()   : placement of each stage's pending B' bits in the packed
//                     inter-stage bus (each stage stores only the slices not yet added)
package adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  localparam int CHUNK_DEFAULT = 8;

  // Bit offset of stage 'stage's pending-B' register inside the packed bus.
  // Stage j keeps width - (j+1)*chunk bits, so offsets are a running sum.
  function automatic int bp_offset(input int width, input int chunk, input int stage);
    int off;
    off = 0;
    for (int j = 0; j < stage; j++) begin
      off += width - (j + 1) * chunk;
    end
    return off;
  endfunction

endpackage : adder_pkg

// File: rtl/chunk_adder.sv
// Module: chunk_adder
// Purpose: CHUNK-bit combinational slice adder, one per pipeline stage.
// Ports:
//   a, b   in  CHUNK  slice operands (b already inverted for subtract)
//   ci     in  1      carry into the slice
//   s      out CHUNK  slice sum
//   co     out 1      carry out of the slice
//   a_msb  out 1      MSB of a (sign bit when this is the top slice)
//   b_msb  out 1      MSB of b (sign bit when this is the top slice)
module chunk_adder
  import adder_pkg::*;
#(
  parameter int CHUNK = CHUNK_DEFAULT
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             a_msb,
  output logic             b_msb
);

  assign {co, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};
  assign a_msb   = a[CHUNK-1];
  assign b_msb   = b[CHUNK-1];

endmodule : chunk_adder

// File: rtl/pipelined_adder.sv
// Module: pipelined_adder
// Purpose: pipelined WIDTH-bit add/subtract with a valid/ready stream interface.
//   The add is split into STAGES = WIDTH/CHUNK slices; stage k adds slice k and
//   registers the carry for stage k+1. Operand slices not yet added travel ahead
//   (skew) and finished sum slices travel behind (deskew) in one accumulator word
//   per stage. WIDTH must be a multiple of CHUNK, with 1..8 stages.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid / in_ready  operand beat handshake (in_ready is combinational)
//   a, b, cin, sub       operands; sub=1 computes a-b and ignores cin
//   out_valid/out_ready  result beat handshake
//   sum, cout, ovf, zero result, carry out (sub: 1 = no borrow), signed overflow, sum==0
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = CHUNK_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int STAGES  = WIDTH / CHUNK;
  localparam int BP_BITS = bp_offset(WIDTH, CHUNK, STAGES - 1);
  localparam int BP_W    = (BP_BITS > 0) ? BP_BITS : 1;

  op_e              op;
  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic             adv;

  // Per-stage state: the valid bits are the only control state.
  logic [STAGES-1:0] valid_q;
  logic [WIDTH-1:0]  acc_q [STAGES];   // finished low slices + not-yet-added A slices
  logic [STAGES-1:0] c_q;              // carry into the next stage (last: cout)
  logic [BP_W-1:0]   bp_q;             // pending B' slices of every stage, packed
  logic              ovf_q;
  logic              zero_q;

  // Next-state values produced by the stage slices.
  wire [WIDTH-1:0]  acc_d [STAGES];
  wire [STAGES-1:0] c_d;
  wire [BP_W-1:0]   bp_d;
  wire              ovf_d;
  wire              zero_d;

  assign op    = op_e'(sub);
  assign b_eff = (op == OP_SUB) ? ~b : b;
  assign c0    = (op == OP_SUB) ? 1'b1 : cin;

  // The whole pipe moves in lockstep: it advances whenever the output slot is
  // empty or being drained, so accept and drain can happen in the same cycle.
  assign adv       = !valid_q[STAGES-1] || out_ready;
  assign in_ready  = adv;
  assign out_valid = valid_q[STAGES-1];
  assign sum       = acc_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign ovf       = ovf_q;
  assign zero      = zero_q;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO   = k * CHUNK;
    localparam int W_IN = WIDTH - LO;   // B' bits still to be added on entry

    wire  [WIDTH-1:0] acc_in;
    wire  [W_IN-1:0]  bp_in;
    wire              ci_in;
    logic [CHUNK-1:0] s;
    logic             co;
    logic             a_msb;
    logic             b_msb;
    logic [WIDTH-1:0] acc_mix;

    if (k == 0) begin : g_src_in
      assign acc_in = a;
      assign bp_in  = b_eff;
      assign ci_in  = c0;
    end else begin : g_src_prev
      localparam int PREV_OFF = bp_offset(WIDTH, CHUNK, k - 1);
      assign acc_in = acc_q[k-1];
      assign bp_in  = bp_q[PREV_OFF +: W_IN];
      assign ci_in  = c_q[k-1];
    end

    chunk_adder #(.CHUNK(CHUNK)) u_chunk (
      .a     (acc_in[LO +: CHUNK]),
      .b     (bp_in[CHUNK-1:0]),
      .ci    (ci_in),
      .s     (s),
      .co    (co),
      .a_msb (a_msb),
      .b_msb (b_msb)
    );

    // NOTE: combinational blocks assign a full default first so no path leaves
    // a bit unassigned, which would otherwise infer a latch.
    always_comb begin
      acc_mix             = acc_in;
      acc_mix[LO +: CHUNK] = s;
    end

    assign acc_d[k] = acc_mix;
    assign c_d[k]   = co;

    if (k == STAGES - 1) begin : g_final
      // Only the top slice sees the operand sign bits.
      assign ovf_d  = (a_msb == b_msb) && (s[CHUNK-1] != a_msb);
      assign zero_d = (acc_mix == '0);
    end else begin : g_mid
      localparam int OFF = bp_offset(WIDTH, CHUNK, k);
      // Slice MSBs only matter for the sign bit in the final stage.
      wire [1:0] unused_msb = {a_msb, b_msb};
      assign bp_d[OFF +: W_IN - CHUNK] = bp_in[W_IN-1:CHUNK];
    end
  end

  // NOTE: the datapath registers are reset together with the valid bits so the
  // result ports read zero after reset rather than stale in-flight data.
  // NOTE: sequential state uses non-blocking assignments so every stage samples
  // its predecessor's pre-edge value and the pipe shifts by exactly one stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      c_q     <= '0;
      bp_q    <= '0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      for (int i = 0; i < STAGES; i++) begin
        acc_q[i] <= '0;
      end
    end else if (adv) begin
      valid_q[0] <= in_valid;
      for (int i = 1; i < STAGES; i++) begin
        valid_q[i] <= valid_q[i-1];
      end
      for (int i = 0; i < STAGES; i++) begin
        acc_q[i] <= acc_d[i];
      end
      c_q    <= c_d;
      bp_q   <= bp_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

endmodule : pipelined_adder

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder at WIDTH=32, CHUNK=8 (4 stages).
// Inputs are driven on the falling edge; outputs are sampled 1 ns later,
// well away from the rising edge that moves the pipe.
module tb_pipelined_adder;

  localparam int WIDTH = 32;
  localparam int CHUNK = 8;
  localparam int LAT   = 4;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
  } beat_t;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  int total = 0;
  int bad   = 0;

  pipelined_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  // Reference: unsigned arithmetic for sum/cout, wide signed arithmetic for ovf.
  function automatic res_t model(input beat_t t);
    res_t        r;
    logic [33:0] u;
    longint      sr;
    if (t.sub) begin
      r.sum  = t.a - t.b;
      r.cout = (t.a >= t.b);
      sr     = longint'($signed(t.a)) - longint'($signed(t.b));
    end else begin
      u      = {2'b00, t.a} + {2'b00, t.b} + {33'd0, t.cin};
      r.sum  = u[31:0];
      r.cout = u[32];
      sr     = longint'($signed(t.a)) + longint'($signed(t.b)) + longint'(t.cin);
    end
    r.ovf  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    r.zero = (r.sum == 32'd0);
    return r;
  endfunction

  // Deterministic stream vectors covering add, add+cin, sub, and sub to zero.
  function automatic beat_t vec(input int i);
    beat_t t;
    t.a   = 32'h9E37_79B9 * (i + 1);
    t.b   = (32'h85EB_CA6B * (i + 3)) ^ (i << 28);
    t.cin = (i % 4 == 1);
    t.sub = (i % 4 >= 2);
    if (i % 4 == 3) t.b = t.a;
    return t;
  endfunction

  task automatic drive(input logic v, input beat_t t);
    in_valid = v;
    a        = t.a;
    b        = t.b;
    cin      = t.cin;
    sub      = t.sub;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, '0);
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({out_valid, sum, cout, ovf, zero} !== 36'd0) begin
      bad++;
      $display("FAIL reset_state: valid=%b sum=%h cout=%b ovf=%b zero=%b, want all 0",
               out_valid, sum, cout, ovf, zero);
    end
    rst = 1'b0;
  endtask

  // One beat into an empty pipe; checks the latency and the hand-computed result.
  task automatic test_single(input string name, input beat_t t, input res_t exp);
    @(negedge clk);
    out_ready = 1'b1;
    drive(1'b1, t);
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s_ready: in_ready=%b want 1", name, in_ready);
    end
    for (int e = 1; e <= LAT; e++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      total++;
      if (e < LAT) begin
        if (out_valid !== 1'b0) begin
          bad++;
          $display("FAIL %s_early: out_valid=%b at +%0d, want 0", name, out_valid, e);
        end
      end else if ({out_valid, sum, cout, ovf, zero} !== {1'b1, exp}) begin
        bad++;
        $display("FAIL %s: valid=%b sum=%h cout=%b ovf=%b zero=%b, want valid=1 sum=%h cout=%b ovf=%b zero=%b",
                 name, out_valid, sum, cout, ovf, zero, exp.sum, exp.cout, exp.ovf, exp.zero);
      end
    end
  endtask

  task automatic test_add();
    test_single("add_carry_chain", '{a:32'h0000_00FF, b:32'h0000_0001, cin:1'b0, sub:1'b0},
                '{sum:32'h0000_0100, cout:1'b0, ovf:1'b0, zero:1'b0});
    test_single("add_wrap_zero",   '{a:32'hFFFF_FFFF, b:32'h0000_0001, cin:1'b0, sub:1'b0},
                '{sum:32'h0000_0000, cout:1'b1, ovf:1'b0, zero:1'b1});
    test_single("add_pos_ovf",     '{a:32'h7FFF_FFFF, b:32'h0000_0001, cin:1'b0, sub:1'b0},
                '{sum:32'h8000_0000, cout:1'b0, ovf:1'b1, zero:1'b0});
    test_single("add_cin",         '{a:32'h0000_0001, b:32'h0000_0002, cin:1'b1, sub:1'b0},
                '{sum:32'h0000_0004, cout:1'b0, ovf:1'b0, zero:1'b0});
  endtask

  task automatic test_sub();
    test_single("sub_borrow",      '{a:32'h0000_0005, b:32'h0000_0007, cin:1'b0, sub:1'b1},
                '{sum:32'hFFFF_FFFE, cout:1'b0, ovf:1'b0, zero:1'b0});
    test_single("sub_neg_ovf",     '{a:32'h8000_0000, b:32'h0000_0001, cin:1'b0, sub:1'b1},
                '{sum:32'h7FFF_FFFF, cout:1'b1, ovf:1'b1, zero:1'b0});
    test_single("sub_ignores_cin", '{a:32'h0000_0003, b:32'h0000_0003, cin:1'b1, sub:1'b1},
                '{sum:32'h0000_0000, cout:1'b1, ovf:1'b0, zero:1'b1});
  endtask

  // Streams n beats, optionally stalling out_ready in [stall_lo, stall_hi).
  task automatic run_stream(input string name, input int n, input int stall_lo,
                            input int stall_hi, input bit check_lat);
    res_t  expq [$];
    int    accq [$];
    res_t  exp;
    res_t  prev;
    int    acc;
    int    sent = 0;
    int    got  = 0;
    bit    prev_stall = 1'b0;
    for (int cyc = 0; cyc < n + 40 && got < n; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= stall_lo && cyc < stall_hi);
      if (sent < n) drive(1'b1, vec(sent));
      else          in_valid = 1'b0;
      #1;
      if (prev_stall) begin
        total++;
        if ({out_valid, sum, cout, ovf, zero} !== {1'b1, prev}) begin
          bad++;
          $display("FAIL %s_hold: valid=%b sum=%h cout=%b ovf=%b zero=%b, want held sum=%h",
                   name, out_valid, sum, cout, ovf, zero, prev.sum);
        end
      end
      if (out_valid && !out_ready) begin
        total++;
        if (in_ready !== 1'b0) begin
          bad++;
          $display("FAIL %s_stall_ready: in_ready=%b want 0 at cycle %0d", name, in_ready, cyc);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev       = '{sum:sum, cout:cout, ovf:ovf, zero:zero};
      if (out_valid && out_ready) begin
        total++;
        if (expq.size() == 0) begin
          bad++;
          $display("FAIL %s_extra: unexpected result sum=%h, want none", name, sum);
        end else begin
          exp = expq.pop_front();
          acc = accq.pop_front();
          if ({sum, cout, ovf, zero} !== exp) begin
            bad++;
            $display("FAIL %s_beat%0d: sum=%h cout=%b ovf=%b zero=%b, want sum=%h cout=%b ovf=%b zero=%b",
                     name, got, sum, cout, ovf, zero, exp.sum, exp.cout, exp.ovf, exp.zero);
          end
          if (check_lat) begin
            total++;
            if (cyc - acc !== LAT) begin
              bad++;
              $display("FAIL %s_latency%0d: latency=%0d want %0d", name, got, cyc - acc, LAT);
            end
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        expq.push_back(model(vec(sent)));
        accq.push_back(cyc);
        sent++;
      end
    end
    total++;
    if (got != n) begin
      bad++;
      $display("FAIL %s_count: results=%0d want %0d", name, got, n);
    end
    for (int i = 0; i < LAT + 1; i++) begin
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #1;
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL %s_drained: out_valid=%b sum=%h after stream, want 0", name, out_valid, sum);
      end
    end
  endtask

  task automatic test_back_to_back();
    run_stream("b2b", 16, -1, -1, 1'b1);
  endtask

  task automatic test_backpressure();
    run_stream("bp", 12, 6, 12, 1'b0);
  endtask

  task automatic test_reset_in_flight();
    int stale = 0;
    out_ready = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      @(negedge clk);
      drive(1'b1, '{a:32'h1111_1111 * (i + 1), b:32'h2222_2222, cin:1'b0, sub:1'b0});
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL rst_fill: out_valid=%b want 1 before reset", out_valid);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({out_valid, sum, cout, ovf, zero} !== 36'd0) begin
      bad++;
      $display("FAIL rst_async: valid=%b sum=%h cout=%b ovf=%b zero=%b, want all 0",
               out_valid, sum, cout, ovf, zero);
    end
    @(negedge clk);
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      if (out_valid !== 1'b0) stale++;
    end
    total++;
    if (stale != 0) begin
      bad++;
      $display("FAIL rst_stale: %0d cycles with out_valid=1 after release, want 0", stale);
    end
    test_single("rst_recover", '{a:32'h1234_5678, b:32'h1111_1111, cin:1'b0, sub:1'b0},
                '{sum:32'h2345_6789, cout:1'b0, ovf:1'b0, zero:1'b0});
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_backpressure();
    test_reset_in_flight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule : tb_pipelined_adder
